// File: rtl/cache_miss_seq.sv
// ============================================================================
// Module   : cache_miss_seq
// Purpose  : Blocking L1 miss sequencer: victim write-back, then line refill.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module cache_miss_seq #(
   parameter int WAYS       = 4,
   parameter int LINE_WORDS = 4,
   parameter int IDXW       = $clog2(LINE_WORDS)
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    miss_valid,
   output logic                    miss_ready,
   input  logic [31:0]             miss_addr,
   input  logic [31:0]             victim_addr,
   input  logic [32*LINE_WORDS-1:0] victim_line,
   input  logic [WAYS-1:0]         way_replace_en,
   input  logic                    need_send,
   output logic                    repl_en,
   output logic                    wr_valid,
   input  logic                    wr_ready,
   output logic [31:0]             wr_addr,
   output logic [31:0]             wr_data,
   output logic                    wr_last,
   output logic                    rd_req_valid,
   input  logic                    rd_req_ready,
   output logic [31:0]             rd_addr,
   input  logic                    rd_data_valid,
   input  logic [31:0]             rd_data,
   input  logic                    rd_last,
   output logic                    fill_we,
   output logic [WAYS-1:0]         fill_way,
   output logic [IDXW-1:0]         fill_idx,
   output logic [31:0]             fill_data,
   output logic                    busy,
   output logic                    done,
   output logic                    err
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WB    = 3'd1,
      S_RREQ  = 3'd2,
      S_RFILL = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(LINE_WORDS - 1);

   state_t                    state_q, state_d;
   logic [IDXW-1:0]           cnt_q, cnt_d;
   logic [31:0]               rd_addr_q, rd_addr_d;
   logic [31:0]               wr_addr_q, wr_addr_d;
   logic [32*LINE_WORDS-1:0]  line_q, line_d;
   logic [WAYS-1:0]           way_q, way_d;
   logic                      err_q, err_d;

   logic                      accept;
   logic                      cnt_last;

   assign accept   = miss_valid && (state_q == S_IDLE);
   assign cnt_last = (cnt_q == LAST_IDX);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rd_addr_d = rd_addr_q;
      wr_addr_d = wr_addr_q;
      line_d    = line_q;
      way_d     = way_q;
      err_d     = err_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               rd_addr_d = miss_addr;
               wr_addr_d = victim_addr;
               line_d    = victim_line;
               way_d     = way_replace_en;
               cnt_d     = '0;
               state_d   = need_send ? S_WB : S_RREQ;
            end
         end
         S_WB: begin
            if (wr_ready) begin
               if (cnt_last) begin
                  cnt_d   = '0;
                  state_d = S_RREQ;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         S_RREQ: begin
            if (rd_req_ready) begin
               state_d = S_RFILL;
            end
         end
         S_RFILL: begin
            if (rd_data_valid) begin
               // Beat count ends the refill; rd_last is only cross-checked.
               if (rd_last != cnt_last) begin
                  err_d = 1'b1;
               end
               if (cnt_last) begin
                  cnt_d   = '0;
                  state_d = S_DONE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         rd_addr_q <= '0;
         wr_addr_q <= '0;
         line_q    <= '0;
         way_q     <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rd_addr_q <= rd_addr_d;
         wr_addr_q <= wr_addr_d;
         line_q    <= line_d;
         way_q     <= way_d;
         err_q     <= err_d;
      end
   end

   assign miss_ready   = (state_q == S_IDLE);
   assign repl_en      = accept;
   assign wr_valid     = (state_q == S_WB);
   assign wr_addr      = wr_addr_q;
   assign wr_data      = line_q[{cnt_q, 5'd0} +: 32];
   assign wr_last      = (state_q == S_WB) && cnt_last;
   assign rd_req_valid = (state_q == S_RREQ);
   assign rd_addr      = rd_addr_q;
   assign fill_we      = (state_q == S_RFILL) && rd_data_valid;
   assign fill_way     = way_q;
   assign fill_idx     = cnt_q;
   assign fill_data    = rd_data;
   assign busy         = (state_q != S_IDLE);
   assign done         = (state_q == S_DONE);
   assign err          = err_q;

endmodule

`default_nettype wire
